// File: rtl/prog_loader.sv
// prog_loader: streams host words into instruction memory at sequential addresses and holds the core until the load completes.
// Define PROG_LOADER_CHKSUM_EN to treat the in_last word as a checksum of the written words.
module prog_loader #(
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 8,
   parameter int START_ADDR = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              core_run,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   word_count
);
   // Handshake: a word transfers on a rising edge where in_valid && in_ready; in_ready is high only in LOAD.
   localparam logic [ADDR_W:0]   DEPTH = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W-1:0] START = ADDR_W'(START_ADDR);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, ERROR} state_t;

   state_t            state;
   state_t            state_n;
   logic [ADDR_W-1:0] addr;
   logic              accept;
   logic              do_write;
   logic              load_init;
   logic              set_err;
`ifdef PROG_LOADER_CHKSUM_EN
   logic [DATA_W-1:0] sum;
`endif

   assign in_ready = (state == LOAD);
   assign accept   = in_ready && in_valid;

   always_comb begin
      state_n   = state;
      do_write  = 1'b0;
      load_init = 1'b0;
      set_err   = 1'b0;
      case (state)
         IDLE, RUN, ERROR: begin
            if (start) begin
               state_n   = LOAD;
               load_init = 1'b1;
            end
         end
         LOAD: begin
            if (accept) begin
`ifdef PROG_LOADER_CHKSUM_EN
               if (in_last) begin
                  if (sum == in_data) begin
                     state_n = RUN;
                  end else begin
                     state_n = ERROR;
                     set_err = 1'b1;
                  end
               end else
`endif
               // A full memory drops the word rather than wrapping the address.
               if (word_count == DEPTH) begin
                  state_n = ERROR;
                  set_err = 1'b1;
               end else begin
                  do_write = 1'b1;
                  if (in_last) state_n = RUN;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         addr       <= START;
         word_count <= '0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         core_run   <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
`ifdef PROG_LOADER_CHKSUM_EN
         sum        <= '0;
`endif
      end else begin
         state    <= state_n;
         mem_we   <= do_write;
         // Release lags RUN entry by one edge so the final write lands before the first fetch.
         core_run <= (state == RUN) && (state_n == RUN);
         done     <= (state == RUN) && (state_n == RUN);
         if (do_write) begin
            mem_addr   <= addr;
            mem_wdata  <= in_data;
            addr       <= addr + ADDR_W'(1);
            word_count <= word_count + (ADDR_W+1)'(1);
`ifdef PROG_LOADER_CHKSUM_EN
            sum        <= sum + in_data;
`endif
         end
         if (load_init) begin
            addr       <= START;
            word_count <= '0;
            err        <= 1'b0;
`ifdef PROG_LOADER_CHKSUM_EN
            sum        <= '0;
`endif
         end else if (set_err) begin
            err <= 1'b1;
         end
      end
   end
endmodule
